flag_branch_ctrl: RTL and testbench
===================================

# flag_branch_ctrl

Branch-resolution controller for the pipelined CPU's ID stage. It holds the architectural NZCV flag register and forwards same-cycle EX flags to a B.cond in ID. It sequences CBZ resolution against the ID-stage zero-detect result, stalling while the CBZ operand is still in flight, and issues the taken/flush decision to the fetch unit. It also keeps a taken-branch counter and a sticky stall-timeout error for debug.

## Interface
Parameters:
- `MAX_STALL`, 2: maximum consecutive CBZ-operand stall cycles before the error flag is set.
- `CNT_W`, 16: width of the taken-branch counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ex_set_flags`  in  1  instruction in EX is flag-setting (ADDS/SUBS).
- `ex_flags`  in  4  EX ALU flags {N,Z,C,V}, with N at bit 3.
- `id_br_type`  in  2  branch type in ID: 00 none, 01 B, 10 CBZ, 11 B.cond.
- `id_cond`  in  4  ARM condition code for B.cond, 0000 EQ through 1110 AL.
- `id_cbz_zero`  in  1  zero-detect of the forwarded CBZ operand.
- `id_cbz_pending`  in  1  CBZ operand not yet available (load in EX).
- `stall`  out  1  hold PC and IF/ID this cycle.
- `br_taken`  out  1  select branch target for the next PC.
- `flush`  out  1  squash the instruction in IF.
- `flags`  out  4  architectural NZCV register.
- `taken_cnt`  out  `CNT_W`  count of taken branches.
- `stall_err`  out  1  sticky: stall exceeded `MAX_STALL`.

## Operation
- **Flag register:** loads `ex_flags` on each clock where `ex_set_flags`=1; otherwise holds.
- **Effective flags:** equal `ex_flags` when `ex_set_flags`=1 in the same cycle (forwarding); otherwise equal `flags`.
- **Condition evaluation** (standard ARM semantics on the effective flags):
  - EQ/NE test Z; HS/LO test C; MI/PL test N; VS/VC test V.
  - HI is C&!Z; LS is !C|Z.
  - GE is N==V; LT is N!=V.
  - GT is !Z&(N==V); LE is Z|(N!=V).
  - AL is true; 1111 is treated as never.
- **Decision:**
  - B: taken.
  - B.cond: taken if the condition holds.
  - CBZ: taken if `id_cbz_zero`=1 and the FSM is not stalling.
  - none: not taken.
- `flush` = `br_taken`.
- **FSM states:** RUN and WAIT.
  - RUN to WAIT when `id_br_type`=CBZ and `id_cbz_pending`=1; `stall`=1.
  - WAIT holds while pending; `stall`=1 and the stall counter increments.
  - WAIT to RUN when pending deasserts; the CBZ resolves that cycle with `stall`=0.
  - When the stall counter reaches `MAX_STALL` while still pending: `stall_err` sets (sticky until reset), the FSM stays in WAIT, and `stall` stays asserted.
- **Counter:** `taken_cnt` increments on each cycle with `br_taken`=1 and `stall`=0, and wraps modulo 2^`CNT_W`.
- B and B.cond never stall. An `id_br_type` change while in WAIT returns the FSM to RUN.

## Timing
- **Reset values:** `flags`=0000, FSM=RUN, stall counter=0, `taken_cnt`=0, `stall_err`=0. `stall`, `br_taken` and `flush` are therefore 0 once inputs are idle.
- `stall`, `br_taken` and `flush` are combinational from ID/EX inputs and current state, with zero-cycle latency.
- `flags`, `taken_cnt` and `stall_err` are registered; each is visible one cycle after the causing event.
- **Simultaneous events:**
  - Flag write and B.cond in the same cycle: the decision uses the new EX flags, and the register updates at that edge.
  - `stall`=1 forces `br_taken`=0 and `flush`=0.
- Reset asserted mid-WAIT returns all state to reset values immediately, without waiting for the clock.

## Structure
- **Package `cpu_ctrl_pkg`:**
  - `br_type_t` enum (BR_NONE, BR_B, BR_CBZ, BR_COND).
  - `cond_t` enum of the 16 ARM condition codes.
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state enum.
- **Sub-module `cond_eval`:** combinational; inputs are a 4-bit cond and 4-bit NZCV, output is a 1-bit pass. Instantiated once.

## Test plan
- **Reset then idle:** `reset` high, then low with `id_br_type`=00 → `flags`=0000, `stall`=0, `br_taken`=0, `taken_cnt`=0.
- **Flag forwarding:** `ex_set_flags`=1 with `ex_flags`=0100, plus B.cond EQ in the same cycle → `br_taken`=1 and `flush`=1; next cycle `flags`=0100 and `taken_cnt`=1.
- **Signed conditions from stored flags:** `flags`=1000 with no EX write:
  - LT → taken.
  - GE → not taken.
  - then `flags`=1001 with GT → taken.
- **CBZ load-use:** CBZ with `id_cbz_pending`=1 for 1 cycle, then 0 with `id_cbz_zero`=1 → `stall`=1 for one cycle, then `br_taken`=1 and FSM back in RUN.
- **Stall timeout:** pending held high for 3 cycles → `stall_err`=1 after the second WAIT cycle; it stays 1 after pending drops and clears only on `reset`.
- **Counter wrap:** with `CNT_W`=4, issue 17 consecutive B → `taken_cnt`=1.

Source files
------------

// File: rtl/flag_branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the ID-stage branch-resolution controller.
//   br_type_t   : branch type carried in ID (none / B / CBZ / B.cond)
//   cond_t      : the 16 ARM condition codes
//   FLAG_*      : bit positions of N, Z, C, V inside a 4-bit NZCV vector
//   fsm_state_t : CBZ sequencing states
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CBZ  = 2'b10,
    BR_COND = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// flag_branch_ctrl_if
// Signal bundle between the ID/EX pipeline and the branch controller.
//   master : pipeline side, drives EX flags and ID branch info, receives
//            stall / br_taken / flush and the debug state
//   slave  : controller side (flag_branch_ctrl)
// Parameter CNT_W sets the taken-branch counter width.
// -----------------------------------------------------------------------------
interface flag_branch_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             ex_set_flags;
  logic [3:0]       ex_flags;
  logic [1:0]       id_br_type;
  logic [3:0]       id_cond;
  logic             id_cbz_zero;
  logic             id_cbz_pending;
  logic             stall;
  logic             br_taken;
  logic             flush;
  logic [3:0]       flags;
  logic [CNT_W-1:0] taken_cnt;
  logic             stall_err;

  modport master (
    output ex_set_flags, ex_flags, id_br_type, id_cond, id_cbz_zero, id_cbz_pending,
    input  stall, br_taken, flush, flags, taken_cnt, stall_err
  );

  modport slave (
    input  ex_set_flags, ex_flags, id_br_type, id_cond, id_cbz_zero, id_cbz_pending,
    output stall, br_taken, flush, flags, taken_cnt, stall_err
  );

endinterface

// File: rtl/flag_branch_ctrl_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition-code evaluator.
//   cond : 4-bit condition code (EQ..AL, 1111 = never)
//   nzcv : flags {N,Z,C,V}
//   pass : 1 when the condition holds
// -----------------------------------------------------------------------------
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  logic base;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // The upper three bits pick a base test; each odd code is the complement
  // of the even code below it. That also makes 1111 the complement of AL,
  // i.e. "never".
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0:    base = z;                  // EQ / NE
      3'd1:    base = c;                  // HS / LO
      3'd2:    base = n;                  // MI / PL
      3'd3:    base = v;                  // VS / VC
      3'd4:    base = c & ~z;             // HI / LS
      3'd5:    base = (n == v);           // GE / LT
      3'd6:    base = ~z & (n == v);      // GT / LE
      3'd7:    base = 1'b1;               // AL / never
      default: base = 1'b0;
    endcase
  end

  assign pass = base ^ cond[0];

endmodule

// File: rtl/flag_branch_ctrl.sv
// -----------------------------------------------------------------------------
// flag_branch_ctrl
// ID-stage branch-resolution controller.
//   - Holds the architectural NZCV register, loaded from EX on flag-setting ops.
//   - Evaluates B.cond on forwarded EX flags when EX writes flags this cycle.
//   - Stalls CBZ while its operand is still in flight (RUN/WAIT FSM), and
//     raises a sticky stall_err when the wait reaches MAX_STALL cycles.
//   - Counts taken branches (wrapping) for debug.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : flag_branch_ctrl_if.slave (EX flags, ID branch info, stall /
//           br_taken / flush decision, flags, taken_cnt, stall_err)
// -----------------------------------------------------------------------------
module flag_branch_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  flag_branch_ctrl_if.slave   bus
);

  localparam int SW = $clog2(MAX_STALL + 1);

  fsm_state_t       state_reg, state_next;
  logic [SW-1:0]    scnt_reg, scnt_next;
  logic [3:0]       flags_reg;
  logic [CNT_W-1:0] taken_cnt_reg;
  logic             stall_err_reg;

  br_type_t         br_type;
  logic [3:0]       eff_flags;
  logic             cond_pass;
  logic             cbz_wait;
  logic             stall_int;
  logic             taken_int;
  logic             err_set;

  assign br_type   = br_type_t'(bus.id_br_type);

  // A flag-setting op in EX is forwarded straight into this cycle's B.cond.
  assign eff_flags = bus.ex_set_flags ? bus.ex_flags : flags_reg;
  assign cbz_wait  = (br_type == BR_CBZ) && bus.id_cbz_pending;

  cond_eval u_cond_eval (
    .cond (bus.id_cond),
    .nzcv (eff_flags),
    .pass (cond_pass)
  );

  // Next-state, stall and branch decision.
  always_comb begin
    state_next = state_reg;
    scnt_next  = scnt_reg;
    err_set    = 1'b0;
    stall_int  = 1'b0;
    taken_int  = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (cbz_wait) begin
          stall_int  = 1'b1;
          state_next = ST_WAIT;
          scnt_next  = '0;
        end
      end
      ST_WAIT: begin
        if (cbz_wait) begin
          stall_int = 1'b1;
          // Saturate so the counter cannot wrap while the error is held.
          if (scnt_reg < SW'(MAX_STALL)) begin
            scnt_next = scnt_reg + 1'b1;
          end
          // This WAIT cycle brings the count to MAX_STALL (or beyond).
          if (scnt_reg >= SW'(MAX_STALL - 1)) begin
            err_set = 1'b1;
          end
        end else begin
          // Operand arrived, or ID now holds something other than CBZ.
          state_next = ST_RUN;
          scnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_RUN;
        scnt_next  = '0;
      end
    endcase

    if (!stall_int) begin
      case (br_type)
        BR_B:    taken_int = 1'b1;
        BR_COND: taken_int = cond_pass;
        BR_CBZ:  taken_int = bus.id_cbz_zero;
        default: taken_int = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      scnt_reg      <= '0;
      flags_reg     <= 4'b0000;
      taken_cnt_reg <= '0;
      stall_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      scnt_reg  <= scnt_next;
      if (bus.ex_set_flags) begin
        flags_reg <= bus.ex_flags;
      end
      if (taken_int) begin
        taken_cnt_reg <= taken_cnt_reg + 1'b1;
      end
      if (err_set) begin
        stall_err_reg <= 1'b1;
      end
    end
  end

  assign bus.stall     = stall_int;
  assign bus.br_taken  = taken_int;
  assign bus.flush     = taken_int;
  assign bus.flags     = flags_reg;
  assign bus.taken_cnt = taken_cnt_reg;
  assign bus.stall_err = stall_err_reg;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_ctrl
// Directed bench for flag_branch_ctrl. Each stimulus cycle pushes the
// expected outputs onto a scoreboard queue; the entry is popped and compared
// against the DUT half a cycle later. Directed constant checks cover the
// key scenarios (forwarding, signed conditions, CBZ load-use, timeout,
// asynchronous reset, counter wrap).
// -----------------------------------------------------------------------------
module tb_flag_branch_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int CW = 4;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic reset;

  flag_branch_ctrl_if #(.CNT_W(CW)) bus ();

  flag_branch_ctrl #(.MAX_STALL(MS), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string          tag;
    logic           stall;
    logic           taken;
    logic           flush;
    logic [3:0]     flags;
    logic [CW-1:0]  cnt;
    logic           err;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [3:0]    m_flags;
  logic          m_wait;
  int            m_scnt;
  logic [CW-1:0] m_cnt;
  logic          m_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_wait  = 1'b0;
    m_scnt  = 0;
    m_cnt   = '0;
    m_err   = 1'b0;
  endtask

  task automatic drive_idle();
    bus.ex_set_flags   = 1'b0;
    bus.ex_flags       = 4'b0000;
    bus.id_br_type     = BR_NONE;
    bus.id_cond        = 4'b0000;
    bus.id_cbz_zero    = 1'b0;
    bus.id_cbz_pending = 1'b0;
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cyc(input string tag, input logic set, input logic [3:0] ef,
                     input logic [1:0] bt, input logic [3:0] cd,
                     input logic zero, input logic pend);
    exp_t e, g;
    logic [3:0] eff;
    logic cbzw, tk;
    bus.ex_set_flags   = set;
    bus.ex_flags       = ef;
    bus.id_br_type     = bt;
    bus.id_cond        = cd;
    bus.id_cbz_zero    = zero;
    bus.id_cbz_pending = pend;

    eff  = set ? ef : m_flags;
    cbzw = (bt == 2'b10) && pend;
    tk   = 1'b0;
    if (!cbzw) begin
      case (bt)
        2'b01:   tk = 1'b1;
        2'b11:   tk = ref_cond(cd, eff);
        2'b10:   tk = zero;
        default: tk = 1'b0;
      endcase
    end
    e.tag = tag; e.stall = cbzw; e.taken = tk; e.flush = tk;
    e.flags = m_flags; e.cnt = m_cnt; e.err = m_err;
    sb.push_back(e);

    @(negedge clk);
    g = sb.pop_front();
    $display("txn %-10s bt=%0d cond=%0h set=%0b pend=%0b stall=%0b taken=%0b flags=%0h cnt=%0d err=%0b",
             g.tag, bt, cd, set, pend, bus.stall, bus.br_taken, bus.flags, bus.taken_cnt, bus.stall_err);
    chk({g.tag, ".stall"}, 16'(bus.stall),     16'(g.stall));
    chk({g.tag, ".taken"}, 16'(bus.br_taken),  16'(g.taken));
    chk({g.tag, ".flush"}, 16'(bus.flush),     16'(g.flush));
    chk({g.tag, ".flags"}, 16'(bus.flags),     16'(g.flags));
    chk({g.tag, ".cnt"},   16'(bus.taken_cnt), 16'(g.cnt));
    chk({g.tag, ".err"},   16'(bus.stall_err), 16'(g.err));

    @(posedge clk);
    if (set) m_flags = ef;
    if (tk)  m_cnt   = m_cnt + 1'b1;
    if (m_wait) begin
      if (cbzw) begin
        if (m_scnt + 1 >= MS) m_err = 1'b1;
        if (m_scnt < MS) m_scnt++;
      end else begin
        m_wait = 1'b0;
        m_scnt = 0;
      end
    end else if (cbzw) begin
      m_wait = 1'b1;
      m_scnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flags", 16'(bus.flags), 16'h0);
    chk("rst.cnt",   16'(bus.taken_cnt), 16'h0);
    chk("rst.err",   16'(bus.stall_err), 16'h0);
    reset = 1'b0;

    // Reset then idle
    cyc("idle", 1'b0, 4'h0, BR_NONE, COND_EQ, 1'b0, 1'b0);
    chk("idle.state", 16'(dut.state_reg), 16'(ST_RUN));

    // Flag forwarding into a same-cycle B.cond EQ
    cyc("fwd_eq", 1'b1, 4'b0100, BR_COND, COND_EQ, 1'b0, 1'b0);
    chk("fwd.flags", 16'(bus.flags), 16'h4);
    chk("fwd.cnt",   16'(bus.taken_cnt), 16'h1);

    // Signed conditions from stored flags
    cyc("set_n",  1'b1, 4'b1000, BR_NONE, COND_EQ, 1'b0, 1'b0);
    cyc("lt",     1'b0, 4'h0,    BR_COND, COND_LT, 1'b0, 1'b0);
    chk("lt.cnt", 16'(bus.taken_cnt), 16'h2);
    cyc("ge",     1'b0, 4'h0,    BR_COND, COND_GE, 1'b0, 1'b0);
    chk("ge.cnt", 16'(bus.taken_cnt), 16'h2);
    cyc("set_nv", 1'b1, 4'b1001, BR_NONE, COND_EQ, 1'b0, 1'b0);
    cyc("gt",     1'b0, 4'h0,    BR_COND, COND_GT, 1'b0, 1'b0);
    chk("gt.cnt", 16'(bus.taken_cnt), 16'h3);

    // Every condition code against several stored flag patterns
    for (int f = 0; f < 16; f += 5) begin
      cyc("setf", 1'b1, 4'(f), BR_NONE, COND_EQ, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        cyc("cond", 1'b0, 4'h0, BR_COND, 4'(c), 1'b0, 1'b0);
      end
    end

    // B and B.cond ignore a pending CBZ operand
    cyc("b_pend",  1'b0, 4'h0, BR_B,    COND_EQ, 1'b0, 1'b1);
    cyc("al_pend", 1'b0, 4'h0, BR_COND, COND_AL, 1'b0, 1'b1);

    // CBZ load-use: one stall cycle, then resolves taken
    cyc("cbz_p", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    chk("cbz_p.state", 16'(dut.state_reg), 16'(ST_WAIT));
    cyc("cbz_r", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b0);
    chk("cbz_r.state", 16'(dut.state_reg), 16'(ST_RUN));

    // CBZ resolves not-taken without stalling when operand is ready
    cyc("cbz_nz", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b0, 1'b0);

    // Branch-type change while in WAIT returns to RUN
    cyc("chg_p", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    cyc("chg_b", 1'b0, 4'h0, BR_B,   COND_EQ, 1'b0, 1'b1);
    chk("chg.state", 16'(dut.state_reg), 16'(ST_RUN));

    // Stall timeout: pending for three cycles
    cyc("to1", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    cyc("to2", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    chk("to2.err", 16'(bus.stall_err), 16'h0);
    cyc("to3", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    chk("to3.err", 16'(bus.stall_err), 16'h1);
    cyc("to_rel", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b0);
    cyc("to_idle", 1'b0, 4'h0, BR_NONE, COND_EQ, 1'b0, 1'b0);
    chk("to_idle.err", 16'(bus.stall_err), 16'h1);

    // Asynchronous reset in the middle of WAIT
    cyc("ar_p", 1'b0, 4'h0, BR_CBZ, COND_EQ, 1'b1, 1'b1);
    reset = 1'b1;
    #2;
    chk("ar.flags", 16'(bus.flags), 16'h0);
    chk("ar.cnt",   16'(bus.taken_cnt), 16'h0);
    chk("ar.err",   16'(bus.stall_err), 16'h0);
    chk("ar.state", 16'(dut.state_reg), 16'(ST_RUN));
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc("ar_idle", 1'b0, 4'h0, BR_NONE, COND_EQ, 1'b0, 1'b0);

    // Counter wrap: 17 consecutive B from zero
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_b", 1'b0, 4'h0, BR_B, COND_EQ, 1'b0, 1'b0);
    end
    chk("wrap.cnt", 16'(bus.taken_cnt), 16'h1);

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      cyc("mix", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
